// File: rtl/qdma_queue_scheduler.sv
// Round-robin descriptor scheduler: per-queue enable/credit state, an external FIFO of active
// queue IDs, and a pop/check/grant/update loop issuing one descriptor grant per queue per pass.
module qdma_queue_scheduler #(
  parameter int unsigned QUEUE_ID_WIDTH = 11,
  parameter int unsigned MAX_QUEUES     = 2048,
  parameter int unsigned CREDIT_WIDTH   = 16
) (
  input  logic                      user_clk,
  input  logic                      user_reset,
  input  logic                      cmd_vld,
  input  logic [1:0]                cmd_op,
  input  logic [QUEUE_ID_WIDTH-1:0] cmd_qid,
  input  logic [CREDIT_WIDTH-1:0]   cmd_credit,
  output logic                      cmd_rdy,
  output logic [QUEUE_ID_WIDTH-1:0] qid_wr_data,
  output logic                      qid_wr_en,
  output logic                      qid_rd_en,
  input  logic [QUEUE_ID_WIDTH-1:0] qid_rd_data,
  input  logic                      qid_rd_vld,
  output logic                      sched_vld,
  output logic [QUEUE_ID_WIDTH-1:0] sched_qid,
  input  logic                      sched_rdy,
  output logic                      err_credit_sat
);

  localparam logic [1:0] OpAddCredit = 2'd0;
  localparam logic [1:0] OpEnable    = 2'd1;
  localparam logic [1:0] OpDisable   = 2'd2;
  localparam logic [CREDIT_WIDTH-1:0] CredOne = CREDIT_WIDTH'(1);

  typedef enum logic [1:0] {StIdle, StCheck, StGrant, StUpdate} state_e;

  state_e r_state, w_state_next;

  logic                      r_active;
  logic [QUEUE_ID_WIDTH-1:0] r_cur_qid;
  logic                      r_push_vld;
  logic [QUEUE_ID_WIDTH-1:0] r_push_qid;
  logic                      r_err_sat;

  logic                      r_en   [MAX_QUEUES];
  logic                      r_inq  [MAX_QUEUES];
  logic [CREDIT_WIDTH-1:0]   r_cred [MAX_QUEUES];

  logic                      w_cmd_acc;
  logic                      w_cmd_en;
  logic                      w_cmd_inq;
  logic [CREDIT_WIDTH-1:0]   w_cmd_cred;
  logic [CREDIT_WIDTH:0]     w_sum;
  logic [CREDIT_WIDTH-1:0]   w_add_cred;
  logic                      w_cmd_push;
  logic                      w_en_we;
  logic                      w_en_val;
  logic                      w_cred_cmd_we;
  logic [CREDIT_WIDTH-1:0]   w_cred_cmd_val;
  logic                      w_cmd_sat;

  logic                      w_cur_en;
  logic [CREDIT_WIDTH-1:0]   w_cur_cred;
  logic [CREDIT_WIDTH-1:0]   w_cur_cred_dec;
  logic                      w_drop;
  logic                      w_repush;
  logic                      w_cred_upd_we;
  logic                      w_inq_clr;

  assign w_cmd_acc  = cmd_vld & cmd_rdy;
  assign w_cmd_en   = r_en[cmd_qid];
  assign w_cmd_inq  = r_inq[cmd_qid];
  assign w_cmd_cred = r_cred[cmd_qid];
  assign w_sum      = {1'b0, w_cmd_cred} + {1'b0, cmd_credit};
  assign w_add_cred = w_sum[CREDIT_WIDTH] ? '1 : w_sum[CREDIT_WIDTH-1:0];

  always_comb begin
    w_cmd_push     = 1'b0;
    w_en_we        = 1'b0;
    w_en_val       = 1'b0;
    w_cred_cmd_we  = 1'b0;
    w_cred_cmd_val = w_add_cred;
    w_cmd_sat      = 1'b0;
    if (w_cmd_acc) begin
      case (cmd_op)
        OpEnable: begin
          w_en_we    = 1'b1;
          w_en_val   = 1'b1;
          w_cmd_push = (w_cmd_cred != '0) && !w_cmd_inq;
        end
        OpDisable: begin
          w_en_we        = 1'b1;
          w_cred_cmd_we  = 1'b1;
          w_cred_cmd_val = '0;
        end
        OpAddCredit: begin
          if (cmd_credit != '0) begin
            w_cred_cmd_we = 1'b1;
            w_cmd_sat     = w_sum[CREDIT_WIDTH];
            w_cmd_push    = w_cmd_en && !w_cmd_inq;
          end
        end
        default: ;
      endcase
    end
  end

  // Credit may already be zero in UPDATE if a DISABLE/ENABLE pair landed during GRANT.
  assign w_cur_en       = r_en[r_cur_qid];
  assign w_cur_cred     = r_cred[r_cur_qid];
  assign w_cur_cred_dec = (w_cur_cred != '0) ? (w_cur_cred - CredOne) : '0;
  assign w_drop         = (r_state == StCheck) && (!w_cur_en || (w_cur_cred == '0));
  assign w_repush       = (r_state == StUpdate) && w_cur_en && (w_cur_cred_dec != '0);
  assign w_cred_upd_we  = (r_state == StUpdate) && (w_cur_cred != '0);
  assign w_inq_clr      = w_drop || ((r_state == StUpdate) && !w_repush);

  always_ff @(posedge user_clk or posedge user_reset) begin
    if (user_reset) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle:   if (qid_rd_vld) w_state_next = StCheck;
      StCheck:  w_state_next = w_drop ? StIdle : StGrant;
      StGrant:  if (sched_rdy) w_state_next = StUpdate;
      StUpdate: w_state_next = StIdle;
      default:  w_state_next = StIdle;
    endcase
  end

  always_comb begin
    qid_rd_en = (r_state == StIdle) && qid_rd_vld;
    sched_vld = (r_state == StGrant);
    cmd_rdy   = r_active && ((r_state == StIdle) || (r_state == StGrant));
  end

  always_ff @(posedge user_clk or posedge user_reset) begin
    if (user_reset) begin
      r_active  <= 1'b0;
      r_cur_qid <= '0;
      r_err_sat <= 1'b0;
    end else begin
      r_active  <= 1'b1;
      r_err_sat <= w_cmd_sat;
      if (qid_rd_en) r_cur_qid <= qid_rd_data;
    end
  end

  // A command accepted on the grant-accept edge would push in UPDATE alongside the re-push;
  // the re-push wins and the command push is held one cycle (cmd_rdy is low in UPDATE).
  always_ff @(posedge user_clk or posedge user_reset) begin
    if (user_reset) begin
      r_push_vld <= 1'b0;
      r_push_qid <= '0;
    end else if (w_cmd_push) begin
      r_push_vld <= 1'b1;
      r_push_qid <= cmd_qid;
    end else if (!(r_push_vld && w_repush)) begin
      r_push_vld <= 1'b0;
    end
  end

  assign qid_wr_en      = w_repush || r_push_vld;
  assign qid_wr_data    = w_repush ? r_cur_qid : r_push_qid;
  assign sched_qid      = r_cur_qid;
  assign err_credit_sat = r_err_sat;

  always_ff @(posedge user_clk or posedge user_reset) begin
    if (user_reset) begin
      r_en <= '{default: 1'b0};
    end else if (w_en_we) begin
      r_en[cmd_qid] <= w_en_val;
    end
  end

  always_ff @(posedge user_clk or posedge user_reset) begin
    if (user_reset) begin
      r_inq <= '{default: 1'b0};
    end else if (w_cmd_push) begin
      r_inq[cmd_qid] <= 1'b1;
    end else if (w_inq_clr) begin
      r_inq[r_cur_qid] <= 1'b0;
    end
  end

  always_ff @(posedge user_clk or posedge user_reset) begin
    if (user_reset) begin
      r_cred <= '{default: '0};
    end else if (w_cred_cmd_we) begin
      r_cred[cmd_qid] <= w_cred_cmd_val;
    end else if (w_cred_upd_we) begin
      r_cred[r_cur_qid] <= w_cur_cred_dec;
    end
  end

endmodule
